// File: rtl/aes_round_sequencer.sv
// Round sequencer for an iterative one-round-per-cycle AES-128/192/256 datapath.
// Issues load/round/last strobes plus round-key index; reports completion over valid/ready.
module aes_round_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       klen,
    input  logic             decrypt,
    input  logic             flush,
    output logic             dp_load,
    output logic             dp_round,
    output logic             dp_last,
    output logic [3:0]       rk_idx,
    output logic             busy,
    output logic             err,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_nr;
    logic [3:0]       r_round;
    logic [3:0]       r_rk_idx;
    logic             r_dec;
    logic             r_err;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic             w_legal;
    logic             w_final;
    logic             w_retire;
    logic [3:0]       w_nr_in;

    always_comb begin
        case (klen)
            2'd0:    w_nr_in = 4'd10;
            2'd1:    w_nr_in = 4'd12;
            default: w_nr_in = 4'd14;
        endcase
    end

    assign w_legal  = (klen != 2'd3);
    assign w_accept = start_valid && start_ready;
    assign w_final  = (r_state == S_ROUND) && (r_round == r_nr);
    assign w_retire = (r_state == S_DONE) && done_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // flush overrides every transition, including a pending start or retire
    always_comb begin
        w_state_next = r_state;
        start_ready  = 1'b0;
        dp_load      = 1'b0;
        dp_round     = 1'b0;
        dp_last      = 1'b0;
        busy         = 1'b0;
        done_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = !flush;
                if (w_accept && w_legal) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                dp_load      = 1'b1;
                busy         = 1'b1;
                w_state_next = S_ROUND;
            end
            S_ROUND: begin
                dp_round = 1'b1;
                dp_last  = w_final;
                busy     = 1'b1;
                if (w_final) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                busy       = 1'b1;
                if (done_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    // r_rk_idx is loaded with the index for the cycle about to start, so it
    // simply holds once the sequence leaves LOAD/ROUND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nr       <= 4'd0;
            r_dec      <= 1'b0;
            r_round    <= 4'd0;
            r_rk_idx   <= 4'd0;
            r_err      <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_nr     <= w_nr_in;
                r_dec    <= decrypt;
                r_rk_idx <= decrypt ? w_nr_in : 4'd0;
            end
            if (!flush) begin
                if (r_state == S_LOAD) begin
                    r_round  <= 4'd1;
                    r_rk_idx <= r_dec ? (r_nr - 4'd1) : 4'd1;
                end else if ((r_state == S_ROUND) && !w_final) begin
                    r_round  <= r_round + 4'd1;
                    r_rk_idx <= r_dec ? (r_nr - r_round - 4'd1) : (r_round + 4'd1);
                end
            end
            if (w_retire && (r_op_count != CNT_MAX)) begin
                r_op_count <= r_op_count + CNT_ONE;
            end
        end
    end

    assign rk_idx   = r_rk_idx;
    assign err      = r_err;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: per-cycle operation-phase model plus directed scenarios
// with hand-computed key-index sequences, latencies and counter values.
module tb_aes_round_sequencer;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [1:0]       klen = 2'd0;
    logic             decrypt = 1'b0;
    logic             flush = 1'b0;
    logic             dp_load;
    logic             dp_round;
    logic             dp_last;
    logic [3:0]       rk_idx;
    logic             busy;
    logic             err;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    aes_round_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .klen       (klen),
        .decrypt    (decrypt),
        .flush      (flush),
        .dp_load    (dp_load),
        .dp_round   (dp_round),
        .dp_last    (dp_last),
        .rk_idx     (rk_idx),
        .busy       (busy),
        .err        (err),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation is described by its phase k (cycles since the
    // handshake). k=1 load, k=2..Nr+1 round r=k-1, k>=Nr+2 waiting for the consumer.
    int m_active = 0;
    int m_k      = 0;
    int m_nr     = 0;
    int m_dec    = 0;
    int m_cnt    = 0;
    int m_rk     = 0;
    int m_err    = 0;

    always @(negedge clk) begin
        int e_load, e_round, e_last, e_done, r;
        if (!rst_n) begin
            m_active = 0; m_k = 0; m_nr = 0; m_dec = 0;
            m_cnt = 0; m_rk = 0; m_err = 0;
        end else begin
            r       = m_k - 1;
            e_load  = (m_active != 0 && m_k == 1) ? 1 : 0;
            e_round = (m_active != 0 && m_k >= 2 && m_k <= m_nr + 1) ? 1 : 0;
            e_last  = (e_round != 0 && r == m_nr) ? 1 : 0;
            e_done  = (m_active != 0 && m_k >= m_nr + 2) ? 1 : 0;
            if (e_load != 0)  m_rk = (m_dec != 0) ? m_nr : 0;
            if (e_round != 0) m_rk = (m_dec != 0) ? (m_nr - r) : r;

            check("m_start_ready", int'(start_ready), (m_active == 0 && !flush) ? 1 : 0);
            check("m_busy",        int'(busy),        m_active);
            check("m_dp_load",     int'(dp_load),     e_load);
            check("m_dp_round",    int'(dp_round),    e_round);
            check("m_dp_last",     int'(dp_last),     e_last);
            check("m_done_valid",  int'(done_valid),  e_done);
            check("m_err",         int'(err),         m_err);
            check("m_rk_idx",      int'(rk_idx),      m_rk);
            check("m_op_count",    int'(op_count),    m_cnt);

            m_err = 0;
            if (flush) begin
                m_active = 0;
            end else if (m_active == 0) begin
                if (start_valid) begin
                    if (klen == 2'd3) begin
                        m_err = 1;
                    end else begin
                        m_active = 1;
                        m_k      = 1;
                        m_nr     = 10 + 2 * int'(klen);
                        m_dec    = int'(decrypt);
                    end
                end
            end else if (e_done != 0) begin
                if (done_ready) begin
                    m_active = 0;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end else begin
                m_k++;
            end
        end
    end

    task automatic run_op(input logic [1:0] kl, input logic dc, input int hold,
                          output int load_rk, output int first_rk, output int last_rk,
                          output int n_rounds, output int n_last, output int lat);
        bit seen;
        @(posedge clk); #1;
        start_valid = 1'b1; klen = kl; decrypt = dc; done_ready = (hold == 0);
        @(negedge clk);
        check("hs_start_ready", int'(start_ready), 1);
        @(posedge clk); #1;
        start_valid = 1'b0; klen = 2'd3; decrypt = ~dc;
        load_rk = -1; first_rk = -1; last_rk = -1; n_rounds = 0; n_last = 0; lat = 0; seen = 0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (dp_load) load_rk = int'(rk_idx);
            if (dp_round) begin
                if (n_rounds == 0) first_rk = int'(rk_idx);
                n_rounds++;
            end
            if (dp_last) begin
                n_last++;
                last_rk = int'(rk_idx);
            end
            if (done_valid) begin
                seen = 1;
                lat  = cyc;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 done_ready = 1'b1;
            @(negedge clk);
            check("bp_done_valid", int'(done_valid), 1);
            check("bp_start_ready", int'(start_ready), 0);
        end
        @(posedge clk); #1;
        done_ready = 1'b0;
        @(negedge clk);
        check("post_start_ready", int'(start_ready), 1);
        check("post_done_valid", int'(done_valid), 0);
    endtask

    initial begin
        int lr, fr, la, nr, nl, lt;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_start_ready", int'(start_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_op_count", int'(op_count), 0);
        check("rst_rk_idx", int'(rk_idx), 0);

        run_op(2'd0, 1'b0, 0, lr, fr, la, nr, nl, lt);
        $display("op enc128: load_rk=%0d first=%0d last=%0d rounds=%0d lat=%0d cnt=%0d", lr, fr, la, nr, lt, op_count);
        check("e128_load_rk", lr, 0);
        check("e128_first_rk", fr, 1);
        check("e128_last_rk", la, 10);
        check("e128_rounds", nr, 10);
        check("e128_last_cnt", nl, 1);
        check("e128_latency", lt, 12);
        check("e128_op_count", int'(op_count), 1);

        run_op(2'd2, 1'b1, 0, lr, fr, la, nr, nl, lt);
        $display("op dec256: load_rk=%0d first=%0d last=%0d rounds=%0d lat=%0d cnt=%0d", lr, fr, la, nr, lt, op_count);
        check("d256_load_rk", lr, 14);
        check("d256_first_rk", fr, 13);
        check("d256_last_rk", la, 0);
        check("d256_rounds", nr, 14);
        check("d256_latency", lt, 16);
        check("d256_op_count", int'(op_count), 2);

        run_op(2'd1, 1'b0, 5, lr, fr, la, nr, nl, lt);
        $display("op enc192 bp: load_rk=%0d first=%0d last=%0d rounds=%0d lat=%0d cnt=%0d", lr, fr, la, nr, lt, op_count);
        check("e192_last_rk", la, 12);
        check("e192_latency", lt, 14);
        check("e192_op_count", int'(op_count), 3);

        @(posedge clk); #1;
        start_valid = 1'b1; klen = 2'd3; decrypt = 1'b0;
        @(negedge clk);
        check("ill_start_ready", int'(start_ready), 1);
        @(posedge clk); #1;
        start_valid = 1'b0; klen = 2'd0;
        @(negedge clk);
        check("ill_err", int'(err), 1);
        check("ill_busy", int'(busy), 0);
        check("ill_dp_load", int'(dp_load), 0);
        @(negedge clk);
        check("ill_err_clear", int'(err), 0);
        check("ill_op_count", int'(op_count), 3);
        $display("op illegal klen: err pulse seen, cnt=%0d", op_count);

        @(posedge clk); #1;
        start_valid = 1'b1; klen = 2'd0; decrypt = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("fl_round5", int'(dp_round), 1);
        check("fl_rk5", int'(rk_idx), 5);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl_busy", int'(busy), 0);
        check("fl_dp_round", int'(dp_round), 0);
        check("fl_done_valid", int'(done_valid), 0);
        check("fl_op_count", int'(op_count), 3);
        $display("op flush at round 5: busy=%0d cnt=%0d", busy, op_count);

        run_op(2'd0, 1'b1, 0, lr, fr, la, nr, nl, lt);
        $display("op dec128 after flush: load_rk=%0d last=%0d rounds=%0d lat=%0d cnt=%0d", lr, la, nr, lt, op_count);
        check("d128_load_rk", lr, 10);
        check("d128_last_rk", la, 0);
        check("d128_latency", lt, 12);

        @(posedge clk); #1;
        flush = 1'b1; start_valid = 1'b1; klen = 2'd0; decrypt = 1'b0;
        @(negedge clk);
        check("fi_start_ready", int'(start_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        check("fi_busy", int'(busy), 0);
        $display("op flush+start in idle: busy=%0d", busy);

        run_op(2'd1, 1'b1, 0, lr, fr, la, nr, nl, lt);
        run_op(2'd2, 1'b0, 0, lr, fr, la, nr, nl, lt);
        $display("op saturation: cnt=%0d", op_count);
        check("sat_op_count", int'(op_count), 3);

        @(posedge clk); #1;
        start_valid = 1'b1; klen = 2'd1; decrypt = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("ar_start_ready", int'(start_ready), 1);
        check("ar_busy", int'(busy), 0);
        check("ar_dp_round", int'(dp_round), 0);
        check("ar_rk_idx", int'(rk_idx), 0);
        check("ar_op_count", int'(op_count), 0);
        check("ar_done_valid", int'(done_valid), 0);
        $display("op async reset mid-round: busy=%0d cnt=%0d", busy, op_count);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(2'd0, 1'b0, 0, lr, fr, la, nr, nl, lt);
        $display("op enc128 after reset: last=%0d lat=%0d cnt=%0d", la, lt, op_count);
        check("rr_latency", lt, 12);
        check("rr_op_count", int'(op_count), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
